// File: rtl/demux_mcast.sv
// demux_mcast: receive-side splitter. Buffers a 256-bit packet stream in a
// small show-ahead FIFO and steers each packet to one or more of seven
// crossbar destinations. Unicast packets follow their exit field. Multicast
// packets are replicated from a per-index mask table, one copy per cycle,
// always in ascending port order.
module demux_mcast #(
  parameter int DataWidth          = 256,
  parameter int MulticastBitPos    = 253,
  parameter int ExitPos            = 160,
  parameter int ExitWidth          = 4,
  parameter int IndexPos           = 128,
  parameter int IndexWidth         = 8,
  parameter int MulticastTablesize = 256,
  parameter int InBufferDepth      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DataWidth-1:0]  in,
  output logic                  in_avail,
  input  logic [6:0]            out_avail,
  input  logic                  cfg_we,
  input  logic [IndexWidth-1:0] cfg_addr,
  input  logic [6:0]            cfg_mask,
  output logic [DataWidth-1:0]  out_local,
  output logic [DataWidth-1:0]  out_yneg,
  output logic [DataWidth-1:0]  out_ypos,
  output logic [DataWidth-1:0]  out_xpos,
  output logic [DataWidth-1:0]  out_xneg,
  output logic [DataWidth-1:0]  out_zpos,
  output logic [DataWidth-1:0]  out_zneg,
  output logic [6:0]            out_valid,
  output logic                  busy,
  output logic [15:0]           drop_count
);

  localparam int PtrW = $clog2(InBufferDepth);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(InBufferDepth);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_SEND} state_t;

  state_t                r_state, w_state_next;
  logic [DataWidth-1:0]  r_fifo [InBufferDepth];
  logic [PtrW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]         r_count;
  logic [6:0]            r_table [MulticastTablesize];
  logic [6:0]            r_tbl_rd;
  logic [DataWidth-1:0]  r_pkt;
  logic [6:0]            r_rem;
  logic [DataWidth-1:0]  r_out [7];
  logic [15:0]           r_drops;

  logic                  w_full, w_empty, w_push, w_pop;
  logic [DataWidth-1:0]  w_head;
  logic [IndexWidth-1:0] w_head_idx;
  logic [ExitWidth-1:0]  w_exit;
  logic [6:0]            w_lookup_mask, w_target, w_rem_next, w_send_oh;
  logic                  w_fire, w_drop, w_load;

  assign w_full     = (r_count == DepthC);
  assign w_empty    = (r_count == '0);
  assign w_push     = in[DataWidth-1] & ~w_full;
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_head_idx = w_head[IndexPos +: IndexWidth];
  assign in_avail   = ~w_full;

  // FIFO pointer and occupancy bookkeeping.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload storage.
  // NOTE: the storage array has no reset; r_count alone decides which
  // entries are meaningful, so resetting 1k flops would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= in;
  end

  // Mask table: cleared on reset so an unprogrammed index drops the packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MulticastTablesize; i++) r_table[i] <= '0;
    end else if (cfg_we) begin
      r_table[cfg_addr] <= cfg_mask;
    end
  end

  // Synchronous table read issued on pop; a same-edge write returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tbl_rd <= '0;
    else if (w_pop) r_tbl_rd <= r_table[w_head_idx];
  end

  // Destination mask for the packet held in r_pkt.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_lookup_mask = '0;
    w_exit        = r_pkt[ExitPos +: ExitWidth];
    if (r_pkt[MulticastBitPos]) w_lookup_mask = r_tbl_rd;
    else if (w_exit <= ExitWidth'(6)) w_lookup_mask[w_exit[2:0]] = 1'b1;
  end

  // Lowest pending destination is the only candidate: strict order, no skip.
  assign w_target   = r_rem & (~r_rem + 7'd1);
  assign w_rem_next = r_rem & ~w_target;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (!w_empty) w_state_next = S_LOOKUP;
      S_LOOKUP: w_state_next = (w_lookup_mask == '0) ? S_IDLE : S_SEND;
      S_SEND:   if (w_fire && (w_rem_next == '0)) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_pop     = (r_state == S_IDLE) && !w_empty;
    w_drop    = (r_state == S_LOOKUP) && (w_lookup_mask == '0);
    w_load    = (r_state == S_LOOKUP) && (w_lookup_mask != '0);
    w_send_oh = (r_state == S_SEND) ? (w_target & out_avail) : '0;
    w_fire    = |w_send_oh;
    busy      = (r_state != S_IDLE);
  end

  // Packet register, remaining-destination mask and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt   <= '0;
      r_rem   <= '0;
      r_drops <= '0;
    end else begin
      if (w_pop)  r_pkt <= w_head;
      if (w_load) r_rem <= w_lookup_mask;
      else if (w_fire) r_rem <= w_rem_next;
      if (w_drop && (r_drops != 16'hFFFF)) r_drops <= r_drops + 16'd1;
    end
  end

  // Output registers: only the port sent this cycle carries the packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 7; p++) r_out[p] <= '0;
    end else begin
      for (int p = 0; p < 7; p++) r_out[p] <= w_send_oh[p] ? r_pkt : '0;
    end
  end

  // Valid vector mirrors the MSB of each output port.
  always_comb begin
    out_valid = '0;
    for (int p = 0; p < 7; p++) out_valid[p] = r_out[p][DataWidth-1];
  end

  assign out_local  = r_out[0];
  assign out_yneg   = r_out[1];
  assign out_ypos   = r_out[2];
  assign out_xpos   = r_out[3];
  assign out_xneg   = r_out[4];
  assign out_zpos   = r_out[5];
  assign out_zneg   = r_out[6];
  assign drop_count = r_drops;

endmodule

// File: tb/tb_demux_mcast.sv
// Scoreboard bench for demux_mcast: stimulus pushes expected copies
// (port, data, cycle) into a queue; a negedge monitor pops and compares.
module tb_demux_mcast;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_pkt;
  logic         in_avail;
  logic [6:0]   out_avail;
  logic         cfg_we;
  logic [7:0]   cfg_addr;
  logic [6:0]   cfg_mask;
  logic [255:0] out_local, out_yneg, out_ypos, out_xpos, out_xneg, out_zpos, out_zneg;
  logic [6:0]   out_valid;
  logic         busy;
  logic [15:0]  drop_count;

  logic [255:0] w_outs [7];

  typedef struct {
    int           port;
    logic [255:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  demux_mcast dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_pkt),
    .in_avail   (in_avail),
    .out_avail  (out_avail),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_mask   (cfg_mask),
    .out_local  (out_local),
    .out_yneg   (out_yneg),
    .out_ypos   (out_ypos),
    .out_xpos   (out_xpos),
    .out_xneg   (out_xneg),
    .out_zpos   (out_zpos),
    .out_zneg   (out_zneg),
    .out_valid  (out_valid),
    .busy       (busy),
    .drop_count (drop_count)
  );

  assign w_outs[0] = out_local;
  assign w_outs[1] = out_yneg;
  assign w_outs[2] = out_ypos;
  assign w_outs[3] = out_xpos;
  assign w_outs[4] = out_xneg;
  assign w_outs[5] = out_zpos;
  assign w_outs[6] = out_zneg;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] mk_pkt(input bit mc, input logic [3:0] ex,
                                          input logic [7:0] idx, input logic [31:0] pay);
    logic [255:0] p;
    p = '0;
    p[255]     = 1'b1;
    p[253]     = mc;
    p[163:160] = ex;
    p[135:128] = idx;
    p[31:0]    = pay;
    return p;
  endfunction

  task automatic exp_push(input int port, input logic [255:0] d, input int c);
    exp_t e;
    e.port = port;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Present a packet for exactly one rising edge; call just after a negedge.
  task automatic drive(input logic [255:0] p);
    in_pkt = p;
    @(negedge clk);
    in_pkt = '0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [6:0] m);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_mask = m;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Wait until every expected copy has been seen and the FSM is idle.
  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < max_cycles) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("drain pending copies", exp_q.size(), 0);
  endtask

  // Monitor: every nonzero output port must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int p = 0; p < 7; p++) begin
        if (w_outs[p] != '0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected copy: port %0d data %0h cycle %0d", p, w_outs[p], cyc);
          end else begin
            mon_e = exp_q.pop_front();
            check("copy port", p, mon_e.port);
            check("copy data", w_outs[p], mon_e.data);
            if (mon_e.cyc >= 0) check("copy cycle", cyc, mon_e.cyc);
          end
        end
      end
      check("out_valid onehot0", (out_valid & (out_valid - 7'd1)) == 7'd0, 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] pk;
    int w;
    int acc;
    rst       = 1'b0;
    in_pkt    = '0;
    out_avail = 7'h7F;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_mask  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset drop_count", drop_count, 0);
    check("reset out_xpos", out_xpos, 0);
    rst = 1'b1;
    @(negedge clk);
    check("in_avail after reset", in_avail, 1);

    // Unicast exit=3: xpos, three edges after the write edge.
    pk = mk_pkt(1'b0, 4'd3, 8'h00, 32'hA5);
    w  = cyc + 1;
    exp_push(3, pk, w + 3);
    drive(pk);
    wait_idle(20);
    check("unicast drop_count", drop_count, 0);

    // Multicast index 0x12 mask 1010011: local, yneg, xneg, zneg.
    cfg_write(8'h12, 7'b1010011);
    pk = mk_pkt(1'b1, 4'd0, 8'h12, 32'hB0B0);
    w  = cyc + 1;
    exp_push(0, pk, w + 3);
    exp_push(1, pk, w + 4);
    exp_push(4, pk, w + 5);
    exp_push(6, pk, w + 6);
    drive(pk);
    repeat (5) @(negedge clk);
    check("busy before last copy", busy, 1);
    @(negedge clk);
    check("busy after last copy", busy, 0);
    wait_idle(20);

    // Same multicast with xneg stalled for 5 cycles.
    out_avail = 7'b1101111;
    pk = mk_pkt(1'b1, 4'd0, 8'h12, 32'hC3C3);
    w  = cyc + 1;
    exp_push(0, pk, w + 3);
    exp_push(1, pk, w + 4);
    exp_push(4, pk, w + 10);
    exp_push(6, pk, w + 11);
    drive(pk);
    repeat (9) @(negedge clk);
    check("busy during stall", busy, 1);
    out_avail = 7'h7F;
    wait_idle(20);

    // Drops: unicast exit 9, multicast to an unprogrammed index.
    drive(mk_pkt(1'b0, 4'd9, 8'h00, 32'hD1));
    drive(mk_pkt(1'b1, 4'd0, 8'h33, 32'hD2));
    repeat (10) @(negedge clk);
    check("drop_count after drops", drop_count, 2);
    check("busy after drops", busy, 0);

    // Back-pressure: six pushes with all destinations blocked.
    out_avail = 7'h00;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      pk = mk_pkt(1'b0, 4'(i), 8'h00, 32'hE0 + i);
      if (i == 5) check("in_avail full", in_avail, 0);
      if (in_avail) begin
        exp_push(i, pk, -1);
        acc++;
      end
      drive(pk);
    end
    check("accepted packets", acc, 5);
    repeat (3) @(negedge clk);
    check("in_avail still full", in_avail, 0);
    out_avail = 7'h7F;
    wait_idle(100);
    check("in_avail after drain", in_avail, 1);

    // Reset in the middle of a 7-way replication.
    cfg_write(8'h44, 7'h7F);
    pk = mk_pkt(1'b1, 4'd0, 8'h44, 32'hF00D);
    w  = cyc + 1;
    exp_push(0, pk, w + 3);
    exp_push(1, pk, w + 4);
    exp_push(2, pk, w + 5);
    drive(pk);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("outputs cleared by reset", out_valid, 0);
    check("out_ypos cleared by reset", out_ypos, 0);
    check("busy cleared by reset", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("in_avail after mid reset", in_avail, 1);
    check("drop_count after mid reset", drop_count, 0);
    check("no leftover copies", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/demux_mcast.md
Name: demux_mcast

Overview:
- Receive-side splitter at the other end of the switch output link.
- Accepts one 256-bit packet stream from an upstream mux output and steers each packet to one or more of the seven crossbar destinations: local, yneg, ypos, xpos, xneg, zpos, zneg.
- Unicast packets use their exit field. Multicast packets are replicated using a per-index destination-mask table, one copy per cycle.
- Per-destination availability inputs are honoured.

Parameters:
- DataWidth, 256, packet width; bit DataWidth-1 is the valid bit.
- MulticastBitPos, 253, packet bit that marks a multicast packet.
- ExitPos, 160, LSB of the unicast exit port field.
- ExitWidth, 4, width of the exit field.
- IndexPos, 128, LSB of the multicast table index field.
- IndexWidth, 8, width of the index field used for table lookup.
- MulticastTablesize, 256, number of mask entries.
- InBufferDepth, 4, depth of the input FIFO; power of 2, at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- in  input  DataWidth  incoming packet; written when in[DataWidth-1]=1 and in_avail=1.
- in_avail  output  1  input FIFO not full.
- out_avail  input  7  downstream ready; bit order 0 local, 1 yneg, 2 ypos, 3 xpos, 4 xneg, 5 zpos, 6 zneg.
- cfg_we  input  1  table write strobe.
- cfg_addr  input  IndexWidth  table write address.
- cfg_mask  input  7  destination mask to write.
- out_local, out_yneg, out_ypos, out_xpos, out_xneg, out_zpos, out_zneg  output  DataWidth each  registered per-port packet outputs.
- out_valid  output  7  MSB (valid bit) of each out_* port, same bit order as out_avail.
- busy  output  1  FSM not in IDLE.
- drop_count  output  16  packets discarded.

Behaviour:
- Reset (rst=0, asynchronous):
  - All out_* = 0, out_valid = 0, drop_count = 0, busy = 0.
  - FSM in IDLE, FIFO empty, all mask table entries = 0.
  - in_avail = 1 from the first cycle after reset deasserts.
  - Reset asserted mid-replication abandons the packet; no partial copies follow.
- Input FIFO:
  - Show-ahead, depth InBufferDepth.
  - in_avail = ~full.
  - A write while full is ignored; the upstream must not do it.
  - Simultaneous push and pop when full is not permitted, because in_avail is already 0.
- FSM states IDLE, LOOKUP, SEND:
  - IDLE: if the FIFO is not empty, pop the head into pkt_reg, issue a synchronous table read at pkt_reg index, go to LOOKUP.
  - LOOKUP, multicast packet: mask = table entry.
  - LOOKUP, unicast packet: mask = one-hot(exit) when exit ≤ 6.
  - LOOKUP, unicast with exit ≥ 7: mask = 0.
  - LOOKUP exit: if mask == 0, increment drop_count (saturating at 0xFFFF) and go to IDLE. Otherwise load rem_mask and go to SEND.
  - SEND: target p = lowest set bit of rem_mask. Strict order with no skipping: if out_avail[p]=0, hold (head-of-line stall).
  - SEND, out_avail[p]=1: register out_p <= pkt_reg for one cycle and clear bit p.
  - SEND: when rem_mask becomes 0, go to IDLE.
- Output timing:
  - Every out_* port not driven this cycle is registered to 0, so each copy is a one-cycle pulse.
  - At most one out_valid bit is high per cycle.
- Latency:
  - Packet written to an empty FIFO at edge t: popped at t+1, LOOKUP at t+2, first copy visible after edge t+3.
  - Each further copy follows one cycle later when out_avail allows.
- Throughput: one packet per 3 + (copies−1) cycles minimum.
- Table writes:
  - cfg_we writes cfg_mask at cfg_addr at the clock edge.
  - A write in the same cycle as a read of the same address: the read returns the old value (read-first).
  - Writes are accepted in any FSM state.
- Packets that fail in[DataWidth-1]=0 are never stored.

Test Plan:
- Reset, then unicast packet with valid=1, bit253=0, exit=3, payload 0xA5 -> out_xpos carries the packet with out_valid=0001000 exactly 3 cycles after the write; all other ports 0; drop_count=0.
- Write table[0x12]=7'b1010011, then multicast packet with index 0x12, all out_avail=1 -> copies on local, yneg, xneg, zneg on 4 consecutive cycles, in that order; busy drops after the last copy.
- Same multicast packet with out_avail[4]=0 held for 5 cycles -> local and yneg are sent, then 5 idle cycles, then xneg and zneg; no copy is reordered or duplicated.
- Unicast exit=9, plus multicast to an index whose entry is 0 -> no outputs; drop_count=2.
- Push 6 back-to-back unicast packets while out_avail=0 -> in_avail=0 once 4 are buffered plus 1 in pkt_reg. Release out_avail -> all accepted packets delivered in order; none lost.
- Multicast to mask 7'b1111111 with rst asserted after the 3rd copy -> outputs 0 immediately; no further copies after reset release; in_avail=1.
